// File: rtl/softmax_ctrl_pkg.sv
// Shared configuration for the softmax row controller: datapath sizing and
// FSM state encodings used by the controller and its testbenches.
package softmax_ctrl_pkg;

  localparam int OUTPUT_BUF_DATASIZE = 16;
  localparam int FIXPOINT_FRAC       = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAX  = 3'd1,
    ST_SUM  = 3'd2,
    ST_LN   = 3'd3,
    ST_NORM = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid+data delay line; the valid bits are clearable so a stage
// change can flush beats in flight. Data registers carry no reset.
module valid_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_vld  = i_vld;
      assign o_data = i_data;
    end else begin : g_pipe
      logic [DEPTH-1:0] r_vld_p;
      logic [WIDTH-1:0] r_data_p [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
          r_vld_p <= '0;
        end else begin
          r_vld_p[0] <= i_vld;
          for (int k = 1; k < DEPTH; k++) r_vld_p[k] <= r_vld_p[k-1];
        end
      end

      always_ff @(posedge clk) begin
        r_data_p[0] <= i_data;
        for (int k = 1; k < DEPTH; k++) r_data_p[k] <= r_data_p[k-1];
      end

      assign o_vld  = r_vld_p[DEPTH-1];
      assign o_data = r_data_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/softmax_ctrl.sv
// Softmax row sequencer: max scan, sum-of-exp scan, ln handshake, then a
// normalizing scan whose results are written back through the latency pipe.
module softmax_ctrl
  import softmax_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int EXP_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_len,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              is_stage1,
  output logic              is_stage2,
  output logic              is_stage3,
  output logic              is_stage4,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              ln_start,
  input  logic              ln_done,
  output logic              busy,
  output logic              done
);

  // Stage cycle counter needs headroom beyond the address range for drain cycles.
  localparam int              CNT_W    = ADDR_W + 2;
  localparam logic [CNT_W-1:0] SCAN_OFS = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] NORM_OFS = CNT_W'(RD_LAT + EXP_LAT);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_n, r_addr;
  logic [CNT_W-1:0]  r_cyc, w_last;
  logic              w_scan, w_rd, w_chg;
  logic              w_a_vld, w_b_vld;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr;

  assign w_scan = (r_state == ST_MAX) || (r_state == ST_SUM) || (r_state == ST_NORM);
  assign w_rd   = w_scan && (r_addr != r_n);
  assign w_last = CNT_W'(r_n) + ((r_state == ST_NORM) ? NORM_OFS : SCAN_OFS) - CNT_W'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = (row_len != '0) ? ST_MAX : ST_FIN;
      ST_MAX:  if (r_cyc == w_last) w_next = ST_SUM;
      ST_SUM:  if (r_cyc == w_last) w_next = ST_LN;
      // ln_done is not trusted in the ln_start cycle: it may still hold the previous row's result.
      ST_LN:   if ((r_cyc != '0) && ln_done) w_next = ST_NORM;
      ST_NORM: if (r_cyc == w_last) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_chg = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_addr  <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_next;
      if (w_chg) begin
        r_cyc  <= '0;
        r_addr <= '0;
      end else begin
        if (r_state == ST_LN) r_cyc <= CNT_W'(1);
        else if (w_scan)      r_cyc <= r_cyc + CNT_W'(1);
        if (w_rd) r_addr <= r_addr + ADDR_W'(1);
      end
      if ((r_state == ST_IDLE) && start) r_n <= row_len;
    end
  end

  // Read beat -> accumulator timing (RD_LAT), then on to write-back (EXP_LAT).
  valid_delay_line #(.DEPTH(RD_LAT), .WIDTH(ADDR_W)) u_rd_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_chg),
    .i_vld  (w_rd),
    .i_data (buf_rd_addr),
    .o_vld  (w_a_vld),
    .o_data (w_a_addr)
  );

  valid_delay_line #(.DEPTH(EXP_LAT), .WIDTH(ADDR_W)) u_exp_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_chg),
    .i_vld  (w_a_vld),
    .i_data (w_a_addr),
    .o_vld  (w_b_vld),
    .o_data (w_b_addr)
  );

  assign buf_rd_en   = w_rd;
  assign buf_rd_addr = w_rd ? r_addr : '0;
  assign acc_en      = w_a_vld && ((r_state == ST_MAX) || (r_state == ST_SUM));
  assign buf_wr_en   = w_b_vld && (r_state == ST_NORM);
  assign buf_wr_addr = buf_wr_en ? w_b_addr : '0;
  assign is_stage1   = (r_state == ST_MAX);
  assign is_stage2   = (r_state == ST_SUM);
  assign is_stage3   = (r_state == ST_LN);
  assign is_stage4   = (r_state == ST_NORM);
  assign acc_clr     = ((r_state == ST_IDLE) && start && (row_len != '0)) ||
                       ((r_state == ST_MAX) && (w_next == ST_SUM));
  assign ln_start    = (r_state == ST_LN) && (r_cyc == '0);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);

endmodule

// File: tb/tb_softmax_ctrl.sv
// Self-checking bench for softmax_ctrl: per-row traces are compared against
// stage lengths, address sequences and beat timing derived from N and latencies.
module tb_softmax_ctrl;

  localparam int ADDR_W = 8;
  localparam int RL     = 1;
  localparam int EL     = 2;

  logic              clk = 1'b0;
  logic              rst_n, start, ln_done;
  logic [ADDR_W-1:0] row_len;
  logic              buf_rd_en, buf_wr_en;
  logic [ADDR_W-1:0] buf_rd_addr, buf_wr_addr;
  logic              is_stage1, is_stage2, is_stage3, is_stage4;
  logic              acc_clr, acc_en, ln_start, busy, done;
  logic [26:0]       w_outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  softmax_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RL), .EXP_LAT(EL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .row_len     (row_len),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .is_stage1   (is_stage1),
    .is_stage2   (is_stage2),
    .is_stage3   (is_stage3),
    .is_stage4   (is_stage4),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .ln_start    (ln_start),
    .ln_done     (ln_done),
    .busy        (busy),
    .done        (done)
  );

  assign w_outs = {buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr,
                   is_stage1, is_stage2, is_stage3, is_stage4,
                   acc_clr, acc_en, ln_start, busy, done};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One row: drive start, play the ln unit (ln_done d cycles after ln_start), record and score.
  task automatic run_row(input int n, input int d, input bit restart, input string tag);
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int clr_cnt = 0, lns_cnt = 0, oh_err = 0, rd_err = 0, wr_err = 0, acc_err = 0;
    int ln_rdwr = 0, stage_start = 0, rd_idx = 0, acc_idx = 0, wr_idx = 0;
    int first_norm_rd = -1, ln_wait = -1, last_rd = -1;
    int st_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] prev = 4'b0000, s;
    bit fin = 0, pend = 0, rs = restart;
    int lat;
    @(negedge clk);
    start   = 1'b1;
    row_len = ADDR_W'(n);
    while (!fin && cyc < 4 * n + d + 40) begin
      #1;
      s = {is_stage4, is_stage3, is_stage2, is_stage1};
      if ($countones(s) > 1) oh_err++;
      if (s != prev) begin
        stage_start = cyc; rd_idx = 0; acc_idx = 0; prev = s;
      end
      if (rs && s == 4'b0010) begin pend = 1; rs = 0; end
      if (buf_rd_en) begin
        rd_cnt++; last_rd = int'(buf_rd_addr);
        if (int'(buf_rd_addr) != rd_idx || cyc != stage_start + rd_idx) rd_err++;
        if (s == 4'b1000 && rd_idx == 0) first_norm_rd = cyc;
        rd_idx++;
      end
      if (acc_en) begin
        acc_cnt++;
        if (!(s == 4'b0001 || s == 4'b0010) || cyc != stage_start + RL + acc_idx) acc_err++;
        acc_idx++;
      end
      if (buf_wr_en) begin
        wr_cnt++;
        if (int'(buf_wr_addr) != wr_idx || cyc != first_norm_rd + RL + EL + wr_idx) wr_err++;
        wr_idx++;
      end
      if (s == 4'b0100 && (buf_rd_en || buf_wr_en)) ln_rdwr++;
      if (ln_start) begin lns_cnt++; ln_wait = d; end
      for (int k = 0; k < 4; k++) if (s[k]) st_cnt[k]++;
      if (acc_clr) clr_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; fin = 1; end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (pend) begin start = 1'b1; row_len = 8'd7; pend = 0; end
      if (ln_wait > 0) begin
        ln_wait--;
        if (ln_wait == 0) ln_done = 1'b1;
      end
    end
    chk({tag, "_finished"}, int'(fin), 1);
    #1;
    chk({tag, "_idle_after"}, int'({busy, is_stage1, is_stage2, is_stage3, is_stage4}), 0);
    ln_done = 1'b0;
    lat = (n != 0) ? 1 : 0;
    chk({tag, "_max_len"},  st_cnt[0], lat * (n + RL));
    chk({tag, "_sum_len"},  st_cnt[1], lat * (n + RL));
    chk({tag, "_ln_len"},   st_cnt[2], lat * (d + 1));
    chk({tag, "_norm_len"}, st_cnt[3], lat * (n + RL + EL));
    chk({tag, "_rd_cnt"},   rd_cnt, 3 * n);
    chk({tag, "_wr_cnt"},   wr_cnt, n);
    chk({tag, "_acc_cnt"},  acc_cnt, 2 * n);
    chk({tag, "_rd_seq"},   rd_err, 0);
    chk({tag, "_wr_seq"},   wr_err, 0);
    chk({tag, "_acc_seq"},  acc_err, 0);
    chk({tag, "_last_rd"},  last_rd, n - 1);
    chk({tag, "_onehot"},   oh_err, 0);
    chk({tag, "_ln_rdwr"},  ln_rdwr, 0);
    chk({tag, "_ln_start"}, lns_cnt, lat);
    chk({tag, "_acc_clr"},  clr_cnt, 2 * lat);
    chk({tag, "_done"},     done_cnt, 1);
    chk({tag, "_busy_len"}, busy_cnt,
        (n != 0) ? 2 * (n + RL) + (d + 1) + (n + RL + EL) + 1 : 1);
  endtask

  // Row aborted by reset during the third read of the normalizing scan.
  task automatic run_reset(input int n, input int d);
    int cyc = 0, ln_wait = -1, rd4 = 0, wr_cnt = 0, done_cnt = 0;
    bit hit = 0;
    @(negedge clk);
    start   = 1'b1;
    row_len = ADDR_W'(n);
    while (!hit && cyc < 4 * n + d + 40) begin
      #1;
      if (ln_start) ln_wait = d;
      if (is_stage4 && buf_rd_en) begin
        rd4++;
        if (rd4 == 3) begin rst_n = 1'b0; hit = 1; end
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (ln_wait > 0) begin
        ln_wait--;
        if (ln_wait == 0) ln_done = 1'b1;
      end
    end
    chk("rst_reached_norm", int'(hit), 1);
    rst_n = 1'b1;
    #1;
    chk("rst_outs_zero", int'(w_outs), 0);
    repeat (12) begin
      if (buf_wr_en) wr_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
      #1;
    end
    chk("rst_no_writes", wr_cnt, 0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle", int'(busy), 0);
    ln_done = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    row_len = '0;
    ln_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs_zero", int'(w_outs), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_row(4, 3, 1'b0, "n4");
    run_row(0, 1, 1'b0, "n0");
    run_row(5, 2, 1'b1, "restart_in_sum");
    run_row(3, 20, 1'b0, "ln_wait20");
    run_reset(6, 2);
    run_row(4, 2, 1'b0, "after_reset");
    for (int i = 0; i < 6; i++)
      run_row(int'($urandom_range(1, 24)), int'($urandom_range(1, 6)), 1'b0, "rand");
    run_row(255, 4, 1'b0, "n255");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
